fractal_sync_kary_node: RTL and testbench

Parametrised K-ary barrier aggregation node for the fractal synchronization tree, generalising the fixed two-child 1D node to N_CHILDREN children and 2**ID_WIDTH concurrent barrier IDs. It tracks per-ID arrival masks and releases local barriers (level 0) directly. For higher-level barriers it forwards one aggregated request to the parent and broadcasts the parent's response down to all children. Errors are reported through a sticky error code.

---
 rtl/fractal_sync_kary_node.sv | 271 +++++++++++++++++++++++++++
 tb/tb_fractal_sync_kary_node.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_sync_kary_node.sv
// K-ary barrier aggregation node: per-ID arrival masks, local release at level 0,
// upward forwarding through a small FIFO for higher levels, sticky error reporting.
module fractal_sync_kary_node #(
    parameter int unsigned N_CHILDREN = 4,
    parameter int unsigned ID_WIDTH   = 3,
    parameter int unsigned LVL_WIDTH  = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [N_CHILDREN-1:0]           req_valid_i,
    output logic [N_CHILDREN-1:0]           req_ready_o,
    input  logic [N_CHILDREN*ID_WIDTH-1:0]  req_id_i,
    input  logic [N_CHILDREN*LVL_WIDTH-1:0] req_lvl_i,
    output logic                            rsp_valid_o,
    output logic [ID_WIDTH-1:0]             rsp_id_o,
    output logic                            up_valid_o,
    input  logic                            up_ready_i,
    output logic [ID_WIDTH-1:0]             up_id_o,
    output logic [LVL_WIDTH-1:0]            up_lvl_o,
    input  logic                            up_rsp_valid_i,
    input  logic [ID_WIDTH-1:0]             up_rsp_id_i,
    output logic                            err_o,
    output logic [1:0]                      err_code_o,
    input  logic                            err_clr_i
);

    localparam int unsigned N_IDS = 2 ** ID_WIDTH;
    localparam int unsigned CW    = $clog2(N_CHILDREN);
    localparam int unsigned PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned QW    = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARRIVING,
        ST_WAIT
    } bar_state_e;

    bar_state_e            state_q [N_IDS];
    bar_state_e            state_d [N_IDS];
    logic [N_CHILDREN-1:0] mask_q  [N_IDS];
    logic [N_CHILDREN-1:0] mask_d  [N_IDS];
    logic [LVL_WIDTH-1:0]  lvl_q   [N_IDS];
    logic [LVL_WIDTH-1:0]  lvl_d   [N_IDS];

    logic [CW-1:0] rr_q, rr_d;
    logic [CW:0]   rr_sum;

    logic                  gnt_valid;
    logic [CW-1:0]         gnt_idx;
    logic [N_CHILDREN-1:0] gnt_oh;
    logic [ID_WIDTH-1:0]   acc_id;
    logic [LVL_WIDTH-1:0]  acc_lvl;

    logic                 loc_rel;
    logic                 par_ok;
    logic [1:0]           acc_err;
    logic [1:0]           new_err;
    logic                 push, pop;
    logic [LVL_WIDTH-1:0] push_lvl;

    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_WIDTH-1:0] rsp_id_q, rsp_id_d;
    logic                pend_q, pend_d;
    logic [ID_WIDTH-1:0] pend_id_q, pend_id_d;
    logic                err_q, err_d;
    logic [1:0]          code_q, code_d;

    logic [ID_WIDTH-1:0]  fifo_id_q  [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]  fifo_id_d  [FIFO_DEPTH];
    logic [LVL_WIDTH-1:0] fifo_lvl_q [FIFO_DEPTH];
    logic [LVL_WIDTH-1:0] fifo_lvl_d [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [QW-1:0]        count_q, count_d;
    logic                 fifo_full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fifo_full = (count_q == QW'(FIFO_DEPTH));
    assign pop       = (count_q != '0) && up_ready_i;

    // Round-robin search from rr_q; a parked release or a full FIFO blocks every grant.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        rr_sum    = '0;
        if (rst_ni && !pend_q && !fifo_full) begin
            for (int unsigned i = 0; i < N_CHILDREN; i++) begin
                rr_sum = {1'b0, rr_q} + (CW+1)'(i);
                if (rr_sum >= (CW+1)'(N_CHILDREN)) begin
                    rr_sum = rr_sum - (CW+1)'(N_CHILDREN);
                end
                if (!gnt_valid && req_valid_i[rr_sum[CW-1:0]]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = rr_sum[CW-1:0];
                end
            end
        end
    end

    assign gnt_oh      = N_CHILDREN'(1) << gnt_idx;
    assign req_ready_o = gnt_valid ? gnt_oh : '0;
    assign acc_id      = req_id_i[32'(gnt_idx)*ID_WIDTH +: ID_WIDTH];
    assign acc_lvl     = req_lvl_i[32'(gnt_idx)*LVL_WIDTH +: LVL_WIDTH];

    always_comb begin
        rr_d = rr_q;
        if (gnt_valid) begin
            rr_d = (gnt_idx == CW'(N_CHILDREN - 1)) ? '0 : gnt_idx + CW'(1);
        end
    end

    // Parent release is judged on the pre-update state, so it never races an accept.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        lvl_d    = lvl_q;
        acc_err  = 2'd0;
        loc_rel  = 1'b0;
        push     = 1'b0;
        push_lvl = '0;
        par_ok   = up_rsp_valid_i && (state_q[up_rsp_id_i] == ST_WAIT);
        if (gnt_valid) begin
            case (state_q[acc_id])
                ST_IDLE: begin
                    mask_d[acc_id]  = gnt_oh;
                    lvl_d[acc_id]   = acc_lvl;
                    state_d[acc_id] = ST_ARRIVING;
                end
                ST_ARRIVING: begin
                    if ((mask_q[acc_id] & gnt_oh) != '0) begin
                        acc_err = 2'd1;
                    end else if (acc_lvl != lvl_q[acc_id]) begin
                        acc_err = 2'd2;
                    end else begin
                        mask_d[acc_id] = mask_q[acc_id] | gnt_oh;
                    end
                end
                default: acc_err = 2'd2;
            endcase
            if (state_d[acc_id] == ST_ARRIVING && mask_d[acc_id] == '1) begin
                mask_d[acc_id] = '0;
                if (lvl_d[acc_id] == '0) begin
                    state_d[acc_id] = ST_IDLE;
                    loc_rel         = 1'b1;
                end else begin
                    state_d[acc_id] = ST_WAIT;
                    push            = 1'b1;
                    push_lvl        = lvl_d[acc_id] - LVL_WIDTH'(1);
                end
            end
        end
        if (par_ok) begin
            state_d[up_rsp_id_i] = ST_IDLE;
        end
    end

    // Parent release owns the output slot; a coinciding local release is parked one cycle.
    always_comb begin
        rsp_valid_d = 1'b0;
        rsp_id_d    = '0;
        pend_d      = pend_q;
        pend_id_d   = pend_id_q;
        if (par_ok) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = up_rsp_id_i;
            if (loc_rel) begin
                pend_d    = 1'b1;
                pend_id_d = acc_id;
            end
        end else if (pend_q) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = pend_id_q;
            pend_d      = 1'b0;
        end else if (loc_rel) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = acc_id;
        end
    end

    always_comb begin
        if (acc_err != 2'd0) begin
            new_err = acc_err;
        end else if (up_rsp_valid_i && !par_ok) begin
            new_err = 2'd3;
        end else begin
            new_err = 2'd0;
        end
        err_d  = err_q;
        code_d = code_q;
        if (new_err != 2'd0 && (!err_q || err_clr_i)) begin
            err_d  = 1'b1;
            code_d = new_err;
        end else if (err_clr_i) begin
            err_d  = 1'b0;
            code_d = 2'd0;
        end
    end

    always_comb begin
        fifo_id_d  = fifo_id_q;
        fifo_lvl_d = fifo_lvl_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            fifo_id_d[wr_ptr_q]  = acc_id;
            fifo_lvl_d[wr_ptr_q] = push_lvl;
            wr_ptr_d             = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + QW'(1);
        end else if (!push && pop) begin
            count_d = count_q - QW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < N_IDS; i++) begin
                state_q[i] <= ST_IDLE;
                mask_q[i]  <= '0;
                lvl_q[i]   <= '0;
            end
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_id_q[i]  <= '0;
                fifo_lvl_q[i] <= '0;
            end
            rr_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            pend_q      <= 1'b0;
            pend_id_q   <= '0;
            err_q       <= 1'b0;
            code_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            lvl_q       <= lvl_d;
            fifo_id_q   <= fifo_id_d;
            fifo_lvl_q  <= fifo_lvl_d;
            rr_q        <= rr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            pend_q      <= pend_d;
            pend_id_q   <= pend_id_d;
            err_q       <= err_d;
            code_q      <= code_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign up_valid_o  = (count_q != '0);
    assign up_id_o     = up_valid_o ? fifo_id_q[rd_ptr_q] : '0;
    assign up_lvl_o    = up_valid_o ? fifo_lvl_q[rd_ptr_q] : '0;
    assign err_o       = err_q;
    assign err_code_o  = code_q;

endmodule

// File: tb/tb_fractal_sync_kary_node.sv
// Bench for fractal_sync_kary_node: directed scenarios with literal checks plus a
// queue-based barrier model compared against the outputs on every falling edge.
module tb_fractal_sync_kary_node;

    localparam int N  = 4;
    localparam int IW = 3;
    localparam int LW = 4;
    localparam int FD = 2;
    localparam int NI = 8;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [N-1:0]    req_valid_i, req_ready_o;
    logic [N*IW-1:0] req_id_i;
    logic [N*LW-1:0] req_lvl_i;
    logic            rsp_valid_o;
    logic [IW-1:0]   rsp_id_o;
    logic            up_valid_o, up_ready_i;
    logic [IW-1:0]   up_id_o;
    logic [LW-1:0]   up_lvl_o;
    logic            up_rsp_valid_i;
    logic [IW-1:0]   up_rsp_id_i;
    logic            err_o;
    logic [1:0]      err_code_o;
    logic            err_clr_i;

    fractal_sync_kary_node #(
        .N_CHILDREN(N),
        .ID_WIDTH  (IW),
        .LVL_WIDTH (LW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_id_i      (req_id_i),
        .req_lvl_i     (req_lvl_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_id_o      (rsp_id_o),
        .up_valid_o    (up_valid_o),
        .up_ready_i    (up_ready_i),
        .up_id_o       (up_id_o),
        .up_lvl_o      (up_lvl_o),
        .up_rsp_valid_i(up_rsp_valid_i),
        .up_rsp_id_i   (up_rsp_id_i),
        .err_o         (err_o),
        .err_code_o    (err_code_o),
        .err_clr_i     (err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Barrier status per ID: 0 idle, 1 collecting arrivals, 2 waiting on parent.
    typedef struct {
        int id;
        int lvl;
    } up_t;

    int           m_st   [NI];
    logic [N-1:0] m_mask [NI];
    int           m_lvl  [NI];
    up_t          m_q[$];
    int           m_rr;
    bit           m_pend;
    int           m_pend_id;
    bit           m_rsp_v;
    int           m_rsp_id;
    bit           m_err;
    int           m_code;

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            m_st[i]   = 0;
            m_mask[i] = '0;
            m_lvl[i]  = 0;
        end
        m_q.delete();
        m_rr      = 0;
        m_pend    = 0;
        m_pend_id = 0;
        m_rsp_v   = 0;
        m_rsp_id  = 0;
        m_err     = 0;
        m_code    = 0;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                model_reset();
                chk("rst_ready", 32'(req_ready_o), 0);
                chk("rst_rsp", 32'(rsp_valid_o), 0);
                chk("rst_up", 32'(up_valid_o), 0);
                chk("rst_err", 32'(err_o), 0);
            end else begin
                int   g;
                int   loc_id, par_id, ecode;
                bit   loc_v, par_v, par_wait;
                up_t  e;
                g = -1;
                if (!m_pend && m_q.size() < FD) begin
                    for (int k = 0; k < N; k++) begin
                        if (g < 0 && req_valid_i[(m_rr + k) % N]) g = (m_rr + k) % N;
                    end
                end
                chk("m_ready", 32'(req_ready_o), (g >= 0) ? (32'd1 << g) : 32'd0);
                chk("m_rsp_valid", 32'(rsp_valid_o), 32'(m_rsp_v));
                if (m_rsp_v) chk("m_rsp_id", 32'(rsp_id_o), m_rsp_id);
                chk("m_up_valid", 32'(up_valid_o), 32'(m_q.size() > 0));
                if (m_q.size() > 0) begin
                    chk("m_up_id", 32'(up_id_o), m_q[0].id);
                    chk("m_up_lvl", 32'(up_lvl_o), m_q[0].lvl);
                end
                chk("m_err", 32'(err_o), 32'(m_err));
                chk("m_code", 32'(err_code_o), m_code);

                // advance the model by the upcoming clock edge
                par_id   = int'(up_rsp_id_i);
                par_wait = (m_st[par_id] == 2);
                ecode    = 0;
                loc_v    = 0;
                loc_id   = 0;
                if (m_q.size() > 0 && up_ready_i) void'(m_q.pop_front());
                if (g >= 0) begin
                    int id, lv;
                    id = int'(req_id_i[g*IW +: IW]);
                    lv = int'(req_lvl_i[g*LW +: LW]);
                    m_rr = (g + 1) % N;
                    if (m_st[id] == 0) begin
                        m_st[id] = 1;
                        m_mask[id] = '0;
                        m_mask[id][g] = 1'b1;
                        m_lvl[id] = lv;
                    end else if (m_st[id] == 2) begin
                        ecode = 2;
                    end else if (m_mask[id][g]) begin
                        ecode = 1;
                    end else if (lv != m_lvl[id]) begin
                        ecode = 2;
                    end else begin
                        m_mask[id][g] = 1'b1;
                    end
                    if (m_st[id] == 1 && &m_mask[id]) begin
                        m_mask[id] = '0;
                        if (m_lvl[id] == 0) begin
                            m_st[id] = 0;
                            loc_v = 1;
                            loc_id = id;
                        end else begin
                            m_st[id] = 2;
                            e.id = id;
                            e.lvl = m_lvl[id] - 1;
                            m_q.push_back(e);
                        end
                    end
                end
                par_v = 0;
                if (up_rsp_valid_i) begin
                    if (par_wait) begin
                        m_st[par_id] = 0;
                        par_v = 1;
                    end else if (ecode == 0) begin
                        ecode = 3;
                    end
                end
                if (par_v) begin
                    m_rsp_v = 1;
                    m_rsp_id = par_id;
                    if (loc_v) begin
                        m_pend = 1;
                        m_pend_id = loc_id;
                    end
                end else if (m_pend) begin
                    m_rsp_v = 1;
                    m_rsp_id = m_pend_id;
                    m_pend = 0;
                end else if (loc_v) begin
                    m_rsp_v = 1;
                    m_rsp_id = loc_id;
                end else begin
                    m_rsp_v = 0;
                end
                if (ecode != 0 && (!m_err || err_clr_i)) begin
                    m_err = 1;
                    m_code = ecode;
                end else if (err_clr_i) begin
                    m_err = 0;
                    m_code = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic set_req(input int c, input int id, input int lvl);
        req_valid_i[c]         = 1'b1;
        req_id_i[c*IW +: IW]   = IW'(id);
        req_lvl_i[c*LW +: LW]  = LW'(lvl);
    endtask

    task automatic arrive(input int c, input int id, input int lvl);
        req_valid_i = '0;
        set_req(c, id, lvl);
        #1;
        chk("arrive_gnt", 32'(req_ready_o), 32'd1 << c);
        step();
        req_valid_i = '0;
    endtask

    task automatic do_reset();
        req_valid_i    = '0;
        up_rsp_valid_i = 1'b0;
        err_clr_i      = 1'b0;
        up_ready_i     = 1'b0;
        rst_ni         = 1'b0;
        step();
        rst_ni         = 1'b1;
    endtask

    initial begin
        logic [3:0] rr_exp [5];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst_ni         = 1'b0;
        req_valid_i    = '1;
        req_id_i       = '0;
        req_lvl_i      = '0;
        up_ready_i     = 1'b0;
        up_rsp_valid_i = 1'b0;
        up_rsp_id_i    = '0;
        err_clr_i      = 1'b0;
        step();
        chk("reset_ready", 32'(req_ready_o), 0);
        chk("reset_rsp_valid", 32'(rsp_valid_o), 0);
        chk("reset_rsp_id", 32'(rsp_id_o), 0);
        chk("reset_up_valid", 32'(up_valid_o), 0);
        chk("reset_up_id", 32'(up_id_o), 0);
        chk("reset_up_lvl", 32'(up_lvl_o), 0);
        chk("reset_err", 32'(err_o), 0);
        chk("reset_code", 32'(err_code_o), 0);
        req_valid_i = '0;
        step();
        rst_ni = 1'b1;

        // Local barrier on ID 5
        for (int c = 0; c < N; c++) arrive(c, 5, 0);
        #1;
        chk("local_rsp_valid", 32'(rsp_valid_o), 1);
        chk("local_rsp_id", 32'(rsp_id_o), 5);
        step();
        chk("local_rsp_pulse", 32'(rsp_valid_o), 0);
        arrive(2, 5, 3);
        chk("local_idle_again", 32'(err_o), 0);

        // Upward barrier on ID 2, level 3, with parent backpressure
        do_reset();
        for (int c = 0; c < N; c++) set_req(c, 2, 3);
        for (int c = 0; c < N; c++) begin
            #1;
            chk("up_gnt", 32'(req_ready_o), 32'd1 << c);
            step();
            req_valid_i[c] = 1'b0;
        end
        #1;
        chk("up_valid", 32'(up_valid_o), 1);
        chk("up_id", 32'(up_id_o), 2);
        chk("up_lvl", 32'(up_lvl_o), 2);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("up_hold_valid", 32'(up_valid_o), 1);
            chk("up_hold_id", 32'(up_id_o), 2);
            chk("up_hold_lvl", 32'(up_lvl_o), 2);
        end
        up_ready_i = 1'b1;
        step();
        up_ready_i = 1'b0;
        chk("up_popped", 32'(up_valid_o), 0);
        up_rsp_valid_i = 1'b1;
        up_rsp_id_i    = 3'd2;
        step();
        up_rsp_valid_i = 1'b0;
        chk("parent_rsp_valid", 32'(rsp_valid_o), 1);
        chk("parent_rsp_id", 32'(rsp_id_o), 2);

        // Round-robin with four persistent requesters on distinct IDs
        do_reset();
        set_req(0, 3, 0);
        set_req(1, 4, 0);
        set_req(2, 6, 0);
        set_req(3, 7, 0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_gnt", 32'(req_ready_o), 32'(rr_exp[k]));
            step();
        end
        req_valid_i = '0;
        chk("rr_dup_err", 32'(err_o), 1);
        chk("rr_dup_code", 32'(err_code_o), 1);

        // Release collision: parent release of 4 and local completion of 1 together
        do_reset();
        up_ready_i = 1'b1;
        for (int c = 0; c < N; c++) arrive(c, 4, 1);
        step();
        up_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) arrive(c, 1, 0);
        set_req(3, 1, 0);
        up_rsp_valid_i = 1'b1;
        up_rsp_id_i    = 3'd4;
        #1;
        chk("coll_gnt", 32'(req_ready_o), 32'b1000);
        step();
        req_valid_i    = '0;
        up_rsp_valid_i = 1'b0;
        set_req(0, 6, 0);
        #1;
        chk("coll_first_valid", 32'(rsp_valid_o), 1);
        chk("coll_first_id", 32'(rsp_id_o), 4);
        chk("coll_parked_ready", 32'(req_ready_o), 0);
        req_valid_i = '0;
        step();
        chk("coll_second_valid", 32'(rsp_valid_o), 1);
        chk("coll_second_id", 32'(rsp_id_o), 1);
        step();
        chk("coll_done", 32'(rsp_valid_o), 0);
        chk("coll_no_err", 32'(err_o), 0);

        // Error reporting
        do_reset();
        arrive(1, 0, 0);
        arrive(1, 0, 0);
        chk("err_dup", 32'(err_o), 1);
        chk("err_dup_code", 32'(err_code_o), 1);
        arrive(2, 0, 5);
        chk("err_sticky_code", 32'(err_code_o), 1);
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        chk("err_cleared", 32'(err_o), 0);
        chk("err_cleared_code", 32'(err_code_o), 0);
        up_rsp_valid_i = 1'b1;
        up_rsp_id_i    = 3'd7;
        step();
        up_rsp_valid_i = 1'b0;
        chk("err_parent", 32'(err_o), 1);
        chk("err_parent_code", 32'(err_code_o), 3);

        // FIFO backpressure, then reset mid-stream
        do_reset();
        for (int c = 0; c < N; c++) arrive(c, 1, 2);
        for (int c = 0; c < 3; c++) arrive(c, 3, 2);
        for (int c = 0; c < N; c++) arrive(c, 2, 2);
        set_req(3, 3, 2);
        #1;
        chk("full_no_gnt", 32'(req_ready_o), 0);
        step();
        chk("full_no_gnt2", 32'(req_ready_o), 0);
        chk("full_head_id", 32'(up_id_o), 1);
        chk("full_head_lvl", 32'(up_lvl_o), 1);
        up_ready_i = 1'b1;
        step();
        up_ready_i = 1'b0;
        #1;
        chk("drain_gnt", 32'(req_ready_o), 32'b1000);
        chk("drain_head_id", 32'(up_id_o), 2);
        step();
        req_valid_i = '0;
        chk("refill_valid", 32'(up_valid_o), 1);
        rst_ni = 1'b0;
        #1;
        chk("midrst_up_valid", 32'(up_valid_o), 0);
        chk("midrst_up_id", 32'(up_id_o), 0);
        chk("midrst_rsp", 32'(rsp_valid_o), 0);
        chk("midrst_err", 32'(err_o), 0);
        step();
        rst_ni = 1'b1;
        chk("postrst_up_valid", 32'(up_valid_o), 0);
        for (int c = 0; c < N; c++) arrive(c, 5, 0);
        chk("fresh_rsp_valid", 32'(rsp_valid_o), 1);
        chk("fresh_rsp_id", 32'(rsp_id_o), 5);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
